// File: rtl/cpu_ifetch.sv
// cpu_ifetch: instruction fetch stage with PC, imem req/ack port and prefetch FIFO to decode
module cpu_ifetch #(
  parameter int              AW       = 16,
  parameter int              DEPTH    = 2,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [15:0]     NOP_WORD = 16'hC000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [15:0]   instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] pc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   mem_word [DEPTH];
  logic [AW-1:0] mem_pc   [DEPTH];
  logic          push, pop;
  always_comb begin
    imem_req    = !rst && !redirect && (count < CW'(DEPTH));
    imem_addr   = pc;
    push        = imem_req && imem_ack;
    instr_valid = count != '0;
    pop         = instr_valid && instr_ready && !redirect;
    instr       = instr_valid ? mem_word[rd_ptr] : NOP_WORD;
    instr_pc    = instr_valid ? mem_pc[rd_ptr] : '0;
  end
  // storage is never reset; empty-state outputs are muxed to NOP above
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + AW'(1);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_cpu_ifetch.sv
// tb_cpu_ifetch: directed stimulus with expected-pop scoreboard for cpu_ifetch
module tb_cpu_ifetch;
  typedef struct {
    logic [15:0] w;
    logic [15:0] pc;
  } ent_t;
  logic        clk = 0;
  logic        rst, imem_req, imem_ack, redirect, instr_valid, instr_ready;
  logic [15:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  int          n_pass = 0, n_total = 0;
  ent_t        exp_q[$];
  always #5 clk = ~clk;
  assign imem_rdata = 16'h1234 + imem_addr;
  cpu_ifetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );
  function automatic ent_t mk(int a);
    ent_t e;
    e.w  = 16'(32'h1234 + a);
    e.pc = 16'(a);
    return e;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // monitor: every accepted instruction must match the next expected entry
  always @(negedge clk) begin
    if (!rst && !redirect && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", {16'h0, instr_pc}, 32'hFFFF_FFFF);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_instr", {16'h0, instr}, {16'h0, e.w});
        chk("pop_pc", {16'h0, instr_pc}, {16'h0, e.pc});
      end
    end
  end
  initial begin
    rst = 1; imem_ack = 0; instr_ready = 0; redirect = 0; redirect_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 16'hC000);
    chk("rst_pc", instr_pc, 0);
    rst = 0; imem_ack = 1; instr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(i));
      #1;
      chk("t1_req", imem_req, 1);
      chk("t1_addr", imem_addr, i);
      chk("t1_valid", instr_valid, (i != 0));
      tick();
    end
    imem_ack = 0;
    tick();
    #1 chk("t1_drain_valid", instr_valid, 0);
    rst = 1; instr_ready = 0;
    tick();
    rst = 0; imem_ack = 1;
    exp_q.push_back(mk(0));
    tick();
    tick();
    #1;
    chk("t2_full_req", imem_req, 0);
    chk("t2_full_addr", imem_addr, 2);
    chk("t2_full_instr", instr, 16'h1234);
    tick();
    #1 chk("t2_hold_addr", imem_addr, 2);
    tick();
    instr_ready = 1;
    #1 chk("t2_pop_req", imem_req, 0);
    tick();
    instr_ready = 0;
    #1;
    chk("t2_refill_req", imem_req, 1);
    chk("t2_refill_addr", imem_addr, 2);
    tick();
    redirect = 1; redirect_pc = 16'h0040;
    #1;
    chk("t3_redir_req", imem_req, 0);
    chk("t3_redir_valid", instr_valid, 1);
    tick();
    redirect = 0; imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_req", imem_req, 1);
      chk("t4_stall_addr", imem_addr, 16'h0040);
      chk("t4_stall_valid", instr_valid, 0);
      chk("t4_stall_instr", instr, 16'hC000);
      tick();
    end
    imem_ack = 1;
    exp_q.push_back(mk(16'h0040));
    tick();
    imem_ack = 0; instr_ready = 1;
    #1;
    chk("t4_pc_inc", imem_addr, 16'h0041);
    chk("t4_valid", instr_valid, 1);
    tick();
    redirect = 1; redirect_pc = 16'hFFFF; imem_ack = 1;
    #1 chk("t5_redir_req", imem_req, 0);
    tick();
    redirect = 0;
    exp_q.push_back(mk(16'hFFFF));
    #1 chk("t5_addr_ffff", imem_addr, 16'hFFFF);
    tick();
    exp_q.push_back(mk(0));
    #1 chk("t5_addr_wrap", imem_addr, 16'h0000);
    tick();
    #1 chk("t5_addr_1", imem_addr, 1);
    tick();
    instr_ready = 0;
    tick();
    #1;
    chk("t6_full_req", imem_req, 0);
    chk("t6_full_head", instr_pc, 1);
    rst = 1; redirect = 1; redirect_pc = 16'h0055; instr_ready = 1;
    #1 chk("t6_rst_req", imem_req, 0);
    tick();
    rst = 0; redirect = 0; imem_ack = 0; instr_ready = 0;
    #1;
    chk("t6_valid", instr_valid, 0);
    chk("t6_instr", instr, 16'hC000);
    chk("t6_instr_pc", instr_pc, 0);
    chk("t6_addr", imem_addr, 0);
    chk("t6_req", imem_req, 1);
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cpu_ifetch.md
Name: cpu_ifetch

Overview:
- Instruction fetch stage of the 16-bit MEPHI CPU. It is the producer of the 16-bit instruction word that the control unit decodes.
- Holds the PC and issues word reads to instruction memory over a req/ack interface. Buffers returned words in a small prefetch FIFO and presents them, with their PC, to decode over a valid/ready handshake.
- Accepts a redirect, taken for a branch or a jump, that flushes the FIFO and restarts fetch at a new PC.

Parameters:
AW, 16, PC / instruction-memory word-address width
DEPTH, 2, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, PC loaded on reset
NOP_WORD, 16'hC000, instr value driven when no valid entry (op 4'b1100 = NOP)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  read request
imem_addr  out  AW  word address of request (= pc)
imem_ack  in  1  request accepted; imem_rdata valid this same cycle
imem_rdata  in  16  instruction word
redirect  in  1  branch/jump taken; flush and refetch
redirect_pc  in  AW  new fetch PC
instr  out  16  head-of-FIFO instruction to decode
instr_pc  out  AW  word address of instr
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decode accepts head entry

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC; FIFO count, rd_ptr, wr_ptr <=0. Outputs while and after reset until first fill:
  - imem_req=0 during a reset cycle.
  - instr_valid=0, instr=NOP_WORD, instr_pc=0.
- Reset overrides redirect, ack and ready in the same cycle. Reset mid-transfer discards any ack data.
- imem_req = !rst && !redirect && (count < DEPTH). imem_addr = pc (combinational from register).
- Fetch: a cycle with imem_req && imem_ack pushes {imem_rdata, pc} into the FIFO and sets pc<=pc+1. PC arithmetic is modulo 2^AW: 0xFFFF wraps to 0x0000 for AW=16.
- imem_ack without imem_req is ignored.
- Memory may hold ack low for any number of cycles. imem_addr stays stable while req=1 and ack=0, unless a redirect occurs.
- Output: instr_valid = (count!=0). instr/instr_pc = head entry when valid, else NOP_WORD / 0.
- Pop occurs on instr_valid && instr_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: count==DEPTH drops imem_req, so no push. Pop when full frees a slot. imem_req is then asserted on the next cycle (no same-cycle bypass).
- Empty: no pop, even if instr_ready=1. A word pushed into an empty FIFO is visible on instr the next cycle, giving 1-cycle latency from ack to instr_valid.
- Redirect (redirect=1, rst=0):
  - pc<=redirect_pc; count, rd_ptr, wr_ptr <=0.
  - imem_req is forced 0 that cycle, so no push. A concurrent ack is ignored.
  - Any pop that cycle is discarded: decode must not consume instr during a redirect cycle.
  - Fetch from redirect_pc starts the following cycle.
  - Back-to-back redirects: the last one wins.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- No X propagation: the FIFO storage need not be reset, but outputs are muxed to NOP_WORD/0 when empty.

Test Plan:
1. Reset release, imem_ack=1 constant, imem_rdata=0x1234+addr, instr_ready=1 -> addresses 0,1,2,...; instr_valid first high 1 cycle after first ack, with instr=0x1234, instr_pc=0. Thereafter one instruction per cycle.
2. instr_ready=0, ack=1 -> exactly DEPTH=2 pushes (addr 0,1), then imem_req=0 and imem_addr=2 held. Raise ready one cycle -> pop 0x1234, imem_req=1 on the next cycle.
3. Redirect while FIFO holds 2 entries, redirect_pc=0x0040, ack=1 same cycle -> next cycle count=0, instr_valid=0, imem_addr=0x0040. Data acked in the redirect cycle never appears on instr.
4. Stalling memory: ack low for 3 cycles -> imem_req=1, imem_addr constant, instr_valid=0. Ack on the 4th cycle -> push occurs and pc increments by 1.
5. Wrap: redirect_pc=0xFFFF, ack=1 -> fetch addresses 0xFFFF then 0x0000. instr_pc sequence is 0xFFFF, 0x0000.
6. rst asserted for 1 cycle with FIFO full and redirect=1 -> after the edge pc=RESET_PC, instr_valid=0, instr=0xC000. imem_req=0 during the reset cycle and 1 the cycle after.
